instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter DataWidth, 8, register/operand width.
REQ-002 Parameter NumOpCodeBits, 5, opcode field width.
REQ-003 Parameter ParamBits, 8, param field and PC width.
REQ-004 Parameter NumStatusBits, 6, ALU status width.
REQ-005 Parameter NumRegs, 8, register file depth (3-bit index).
REQ-006 Port clock, input, 1, single clock; all state on rising edge.
REQ-007 Port reset, input, 1, synchronous, active-high.
REQ-008 Port imem_addr, output, 8, instruction address (equals pc).
REQ-009 Port imem_req, output, 1, instruction fetch request.
REQ-010 Port imem_ack, input, 1, imem_data valid this cycle.
REQ-011 Port imem_data, input, 19, instruction: [18:14] opcode, [13:11] rd, [10:8] rs, [7:0] param.
REQ-012 Ports alu_opcode, alu_operand1, alu_operand2, alu_param, outputs, 5/8/8/8, drive the combinational ALU.
REQ-013 Ports alu_result, alu_status, inputs, 8/6, combinational ALU response.
REQ-014 Port status, output, 6, latched flags (0 Carry, 1 Underflow, 2 Zero, 3 Equal, 4 GT, 5 ST).
REQ-015 Ports pc (8), illegal (1), halted (1), outputs.

Function
REQ-016 FSM states FETCH, EXEC, WB; FETCH->EXEC on imem_ack, EXEC->WB always, WB->FETCH always.
REQ-017 FETCH asserts imem_req with imem_addr=pc; no ack holds FETCH with request held; on ack, instruction latched into instr register.
REQ-018 EXEC drives ALU: operand1=reg[rd], operand2=reg[rs], param=param; alu_opcode=instr opcode for ADD,SUB,AND,OR,NOT,XOR,SHL,SHR; SUB for CMP; NOP otherwise.
REQ-019 End of EXEC captures alu_result/alu_status into result/status holding registers; WB commits them.
REQ-020 WB, ALU ops: reg[rd]<=result, status<=captured status; CMP updates status only; VAL writes param to reg[rd], status unchanged.
REQ-021 WB, flow: GOTO pc<=param; IFZ/IFEQ/IFST/IFGT pc<=param if status bit 2/3/5/4 set, else pc+1; IFNZ pc<=param if bit 2 clear; all other opcodes pc<=pc+1.
REQ-022 Branch evaluation uses status as held at start of WB (last ALU/CMP result).
REQ-023 pc increments modulo 256 (0xFF->0x00).
REQ-024 Reserved opcodes (0x0B-0x0F, 0x16-0x1F) behave as NOP and pulse illegal for exactly the WB cycle.
REQ-025 Minimum latency 3 cycles per instruction with same-cycle ack; alu_* outputs are Op_NOP/zero outside EXEC.
REQ-026 NOP, VAL, flow and illegal opcodes leave status unchanged.

Reset
REQ-027 reset high at any edge: state FETCH, pc 0, all registers 0, status 0, illegal 0, halted 0, instr 0; imem_req 0 while reset high.
REQ-028 Reset mid-instruction aborts it; no register, status or pc write occurs in that cycle.

Configuration
REQ-029 Macro SEQ_HALT_EN defined: opcode 5'b1_1111 decodes as HALT; after its WB the FSM enters HALTED, imem_req 0, halted 1, until reset.
REQ-030 SEQ_HALT_EN undefined: 5'b1_1111 is reserved (REQ-024); halted tied 0; no HALTED state.

Structure
REQ-031 Shared package jac_pkg holds opcode constants, status bit indices, width constants, and FSM state enum.
REQ-032 Register file is sub-module jac_regfile: two async read ports, one sync write port, synchronous reset to 0.

Verification
REQ-033 VAL r1,0x05; VAL r2,0x05; CMP r1,r2; IFEQ 0x40 -> status bit3=1, bit2=1, pc=0x40 after fourth WB.
REQ-034 VAL r1,0xF0; VAL r2,0x20; ADD r1,r2 -> r1=0x10, status[0]=1.
REQ-035 imem_ack withheld 5 cycles -> imem_req held, imem_addr stable, no state change; ack -> EXEC next cycle.
REQ-036 pc=0xFF executing NOP -> pc=0x00; opcode 0x0C -> illegal one cycle, registers unchanged.
REQ-037 reset asserted during EXEC of ADD -> destination register unchanged, pc=0, next fetch at 0x00.
REQ-038 SEQ_HALT_EN defined, opcode 0x1F at 0x03 -> halted=1, imem_req=0 for 20 cycles; undefined -> illegal pulse, pc=0x04.

Source files
------------

// File: rtl/jac_pkg.sv
// Shared definitions for the instruction sequencer: widths, opcode map,
// status flag positions, FSM state encoding and small decode helpers.
// SEQ_HALT_EN adds the HALT opcode (5'h1F) and the HALTED state.
package jac_pkg;

  localparam int DATA_W    = 8;
  localparam int OPC_W     = 5;
  localparam int PARAM_W   = 8;
  localparam int STATUS_W  = 6;
  localparam int NUM_REGS  = 8;
  localparam int REG_IDX_W = 3;
  localparam int INSTR_W   = OPC_W + 2 * REG_IDX_W + PARAM_W;

  typedef logic [OPC_W-1:0] opcode_t;

  // ALU-class opcodes form one contiguous range (ADD..SHR) so decode is a compare.
  localparam opcode_t OP_NOP  = 5'h00;
  localparam opcode_t OP_ADD  = 5'h01;
  localparam opcode_t OP_SUB  = 5'h02;
  localparam opcode_t OP_AND  = 5'h03;
  localparam opcode_t OP_OR   = 5'h04;
  localparam opcode_t OP_NOT  = 5'h05;
  localparam opcode_t OP_XOR  = 5'h06;
  localparam opcode_t OP_SHL  = 5'h07;
  localparam opcode_t OP_SHR  = 5'h08;
  localparam opcode_t OP_CMP  = 5'h09;
  localparam opcode_t OP_VAL  = 5'h0A;
  localparam opcode_t OP_GOTO = 5'h10;
  localparam opcode_t OP_IFZ  = 5'h11;
  localparam opcode_t OP_IFEQ = 5'h12;
  localparam opcode_t OP_IFST = 5'h13;
  localparam opcode_t OP_IFGT = 5'h14;
  localparam opcode_t OP_IFNZ = 5'h15;
  localparam opcode_t OP_HALT = 5'h1F;

  // Bit positions inside the status flag vector.
  localparam int ST_CARRY     = 0;
  localparam int ST_UNDERFLOW = 1;
  localparam int ST_ZERO      = 2;
  localparam int ST_EQUAL     = 3;
  localparam int ST_GT        = 4;
  localparam int ST_ST        = 5;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
`ifdef SEQ_HALT_EN
    WB     = 2'd2,
    HALTED = 2'd3
`else
    WB     = 2'd2
`endif
  } seq_state_e;

  // True for opcodes whose result is written back to the register file.
  function automatic logic is_alu_op(opcode_t op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

  // Reserved opcodes execute as NOP and raise the illegal pulse.
  function automatic logic is_reserved(opcode_t op);
    logic r;
    r = ((op >= 5'h0B) && (op <= 5'h0F)) || ((op >= 5'h16) && (op <= 5'h1E));
`ifndef SEQ_HALT_EN
    r = r || (op == OP_HALT);
`endif
    return r;
  endfunction

endpackage

// File: rtl/jac_regfile.sv
// Register file for the sequencer: two asynchronous read ports, one
// synchronous write port, synchronous active-high clear of every entry.
module jac_regfile #(
  parameter int DataWidth = 8,
  parameter int NumRegs   = 8,
  parameter int IdxW      = $clog2(NumRegs)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IdxW-1:0]      raddr_a_i,
  output logic [DataWidth-1:0] rdata_a_o,
  input  logic [IdxW-1:0]      raddr_b_i,
  output logic [DataWidth-1:0] rdata_b_o,
  input  logic                 we_i,
  input  logic [IdxW-1:0]      waddr_i,
  input  logic [DataWidth-1:0] wdata_i
);

  logic [DataWidth-1:0] regs_q [NumRegs];

  // Reset clears every entry and takes priority over a same-cycle write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/instr_sequencer.sv
// Three-phase instruction sequencer (FETCH -> EXEC -> WB) driving an
// external combinational ALU and a request/acknowledge instruction memory.
// SEQ_HALT_EN enables the HALT opcode and the terminal HALTED state;
// without it opcode 5'h1F is reserved and halted is tied low.
//
// Fetch handshake: imem_req is high for every FETCH cycle with imem_addr
// equal to pc and stays high (address stable) until imem_ack; imem_data is
// sampled on the rising edge where imem_req and imem_ack are both high.
// imem_req is forced low while reset is high.
module instr_sequencer
  import jac_pkg::*;
#(
  parameter int DataWidth     = DATA_W,
  parameter int NumOpCodeBits = OPC_W,
  parameter int ParamBits     = PARAM_W,
  parameter int NumStatusBits = STATUS_W,
  parameter int NumRegs       = NUM_REGS,
  localparam int RegIdxBits   = $clog2(NumRegs),
  localparam int InstrBits    = NumOpCodeBits + 2 * RegIdxBits + ParamBits
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic [ParamBits-1:0]     imem_addr,
  output logic                     imem_req,
  input  logic                     imem_ack,
  input  logic [InstrBits-1:0]     imem_data,
  output logic [NumOpCodeBits-1:0] alu_opcode,
  output logic [DataWidth-1:0]     alu_operand1,
  output logic [DataWidth-1:0]     alu_operand2,
  output logic [ParamBits-1:0]     alu_param,
  input  logic [DataWidth-1:0]     alu_result,
  input  logic [NumStatusBits-1:0] alu_status,
  output logic [NumStatusBits-1:0] status,
  output logic [ParamBits-1:0]     pc,
  output logic                     illegal,
  output logic                     halted,
  output logic [1:0]               dbg_state
);

  seq_state_e               state_q;
  logic [ParamBits-1:0]     pc_q;
  logic [ParamBits-1:0]     pc_d;
  logic [InstrBits-1:0]     instr_q;
  logic [DataWidth-1:0]     result_q;
  logic [NumStatusBits-1:0] st_cap_q;
  logic [NumStatusBits-1:0] status_q;
  logic                     illegal_q;
`ifdef SEQ_HALT_EN
  logic                     halted_q;
`endif

  // Instruction fields.
  logic [NumOpCodeBits-1:0] opcode;
  logic [RegIdxBits-1:0]    rd_idx;
  logic [RegIdxBits-1:0]    rs_idx;
  logic [ParamBits-1:0]     param;

  assign opcode = instr_q[InstrBits-1 -: NumOpCodeBits];
  assign rd_idx = instr_q[ParamBits + RegIdxBits +: RegIdxBits];
  assign rs_idx = instr_q[ParamBits +: RegIdxBits];
  assign param  = instr_q[ParamBits-1:0];

  // Register file hookup; writes only happen in WB.
  logic [DataWidth-1:0] rd_data;
  logic [DataWidth-1:0] rs_data;
  logic                 rf_we;
  logic [DataWidth-1:0] rf_wdata;
  logic                 updates_status;

  assign updates_status = is_alu_op(opcode) || (opcode == OP_CMP);
  assign rf_we          = (state_q == WB) && (is_alu_op(opcode) || (opcode == OP_VAL));
  assign rf_wdata       = (opcode == OP_VAL) ? DataWidth'(param) : result_q;

  jac_regfile #(
    .DataWidth (DataWidth),
    .NumRegs   (NumRegs),
    .IdxW      (RegIdxBits)
  ) u_regfile (
    .clk_i     (clock),
    .rst_i     (reset),
    .raddr_a_i (rd_idx),
    .rdata_a_o (rd_data),
    .raddr_b_i (rs_idx),
    .rdata_b_o (rs_data),
    .we_i      (rf_we),
    .waddr_i   (rd_idx),
    .wdata_i   (rf_wdata)
  );

  // ALU is only driven in EXEC; CMP reuses SUB and non-ALU opcodes present NOP.
  always_comb begin
    alu_opcode   = OP_NOP;
    alu_operand1 = '0;
    alu_operand2 = '0;
    alu_param    = '0;
    if (state_q == EXEC) begin
      alu_operand1 = rd_data;
      alu_operand2 = rs_data;
      alu_param    = param;
      if (is_alu_op(opcode)) begin
        alu_opcode = opcode;
      end else if (opcode == OP_CMP) begin
        alu_opcode = OP_SUB;
      end
    end
  end

  // Next pc: conditional branches test the flags as held at the start of WB.
  always_comb begin
    logic take;
    take = 1'b0;
    case (opcode)
      OP_GOTO: take = 1'b1;
      OP_IFZ:  take = status_q[ST_ZERO];
      OP_IFEQ: take = status_q[ST_EQUAL];
      OP_IFST: take = status_q[ST_ST];
      OP_IFGT: take = status_q[ST_GT];
      OP_IFNZ: take = !status_q[ST_ZERO];
      default: take = 1'b0;
    endcase
    pc_d = take ? param : (pc_q + ParamBits'(1));
  end

  // Sequencer FSM with its registered outputs; reset aborts any instruction.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= '0;
      instr_q   <= '0;
      result_q  <= '0;
      st_cap_q  <= '0;
      status_q  <= '0;
      illegal_q <= 1'b0;
`ifdef SEQ_HALT_EN
      halted_q  <= 1'b0;
`endif
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        FETCH: begin
          if (imem_ack) begin
            instr_q <= imem_data;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          result_q  <= alu_result;
          st_cap_q  <= alu_status;
          illegal_q <= is_reserved(opcode);
          state_q   <= WB;
        end
        WB: begin
          if (updates_status) begin
            status_q <= st_cap_q;
          end
          pc_q <= pc_d;
`ifdef SEQ_HALT_EN
          if (opcode == OP_HALT) begin
            state_q  <= HALTED;
            halted_q <= 1'b1;
          end else begin
            state_q <= FETCH;
          end
`else
          state_q <= FETCH;
`endif
        end
`ifdef SEQ_HALT_EN
        HALTED: state_q <= HALTED;
`endif
        default: state_q <= FETCH;
      endcase
    end
  end

  assign imem_req  = (state_q == FETCH) && !reset;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign status    = status_q;
  assign illegal   = illegal_q;
  assign dbg_state = state_q;
`ifdef SEQ_HALT_EN
  assign halted    = halted_q;
`else
  assign halted    = 1'b0;
`endif

endmodule
